// File: rtl/pipe_regfile_sb.sv
// Register file with busy-bit scoreboard, write-through bypass and write-back trace.
// Reads and stall are combinational; busy/busy_cnt/trace update on the next edge.
// Decode holds on stall; write-back is never back-pressured.
module pipe_regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NRD-1:0]     rd_en,
  input  logic [NRD*AW-1:0]  rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]     rd_busy,
  input  logic               issue_valid,
  input  logic [AW-1:0]      issue_rd,
  input  logic               wb_valid,
  input  logic [AW-1:0]      wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic               stall,
  output logic [AW:0]        busy_cnt,
  output logic               trace_valid,
  output logic [AW-1:0]      trace_rd,
  output logic [XLEN-1:0]    trace_data
);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_eff;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] issue_mask;
  logic            wb_act;
  logic            issue_acc;
  logic            raw;
  logic            waw;
  logic            cnt_inc;
  logic            cnt_dec;

  // Register 0 is excluded here, so it never writes, traces or becomes busy.
  assign wb_act     = wb_valid && (wb_rd != '0);
  assign wb_mask    = wb_act ? ({{(NREG-1){1'b0}}, 1'b1} << wb_rd) : '0;
  assign busy_eff   = busy & ~wb_mask;

  always_comb begin
    logic [AW-1:0] a;
    rd_data = '0;
    rd_busy = '0;
    raw     = 1'b0;
    a       = '0;
    for (int p = 0; p < NRD; p++) begin
      a = rd_addr[p*AW +: AW];
      if (wb_act && (wb_rd == a))
        rd_data[p*XLEN +: XLEN] = wb_data;
      else if (a != '0)
        rd_data[p*XLEN +: XLEN] = mem[a];
      rd_busy[p] = busy_eff[a];
      raw        = raw | (rd_en[p] & busy_eff[a]);
    end
  end

  assign waw        = issue_valid & busy_eff[issue_rd];
  assign stall      = raw | waw;
  assign issue_acc  = issue_valid && !stall && (issue_rd != '0);
  assign issue_mask = issue_acc ? ({{(NREG-1){1'b0}}, 1'b1} << issue_rd) : '0;

  // A same-register issue and write-back give +1 and -1: net zero, bit stays set.
  assign cnt_inc = issue_acc;
  assign cnt_dec = wb_act & busy[wb_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wb_act) mem[wb_rd] <= wb_data;
      busy     <= busy_eff | issue_mask;
      busy_cnt <= busy_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid <= 1'b0;
      trace_rd    <= '0;
      trace_data  <= '0;
    end else begin
      trace_valid <= wb_act;
      if (wb_act) begin
        trace_rd   <= wb_rd;
        trace_data <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_regfile_sb.sv
// Directed bench for pipe_regfile_sb at default parameters (XLEN=32, NREG=32, NRD=2).
module tb_pipe_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic [5:0]  busy_cnt;
  logic        trace_valid;
  logic [4:0]  trace_rd;
  logic [31:0] trace_data;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_regfile_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .busy_cnt(busy_cnt),
    .trace_valid(trace_valid), .trace_rd(trace_rd), .trace_data(trace_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rd_en = 2'b00; rd_addr = '0;
    issue_valid = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  // Commit on the rising edge, then settle 1 time unit before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    rd_addr = {5'd5, 5'd0};
    #1;
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_busy_cnt got=%0d exp=0", busy_cnt); end
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_trace_valid got=%b exp=0", trace_valid); end
    n_checks++; if (trace_rd !== 5'd0 || trace_data !== 32'h0) begin n_fail++; $display("FAIL reset_trace got=%0d/%h exp=0/0", trace_rd, trace_data); end
  endtask

  task automatic test_write_bypass();
    idle();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    rd_addr = {5'd0, 5'd3};
    #1;
    n_checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same_cycle got=%h exp=deadbeef", rd_data[31:0]); end
    n_checks++; if (rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL bypass_r0_port got=%h exp=0", rd_data[63:32]); end
    tick();
    wb_valid = 1'b0;
    #1;
    n_checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stored_read got=%h exp=deadbeef", rd_data[31:0]); end
    n_checks++; if (trace_valid !== 1'b1 || trace_rd !== 5'd3 || trace_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL trace_capture got=%b/%0d/%h exp=1/3/deadbeef", trace_valid, trace_rd, trace_data); end
    tick();
    n_checks++; if (trace_valid !== 1'b0 || trace_rd !== 5'd3 || trace_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL trace_hold got=%b/%0d/%h exp=0/3/deadbeef", trace_valid, trace_rd, trace_data); end
  endtask

  task automatic test_load_use_raw();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_issue_stall got=%b exp=0", stall); end
    tick();
    issue_valid = 1'b0;
    rd_en = 2'b10; rd_addr = {5'd7, 5'd0};
    #1;
    n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL raw_busy_cnt_set got=%0d exp=1", busy_cnt); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (stall !== 1'b1 || rd_busy !== 2'b10) begin
        n_fail++; $display("FAIL raw_stall_cycle%0d got=%b/%b exp=1/10", i, stall, rd_busy); end
      tick();
    end
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
    #1;
    n_checks++; if (stall !== 1'b0 || rd_busy !== 2'b00) begin n_fail++; $display("FAIL raw_release got=%b/%b exp=0/00", stall, rd_busy); end
    n_checks++; if (rd_data[63:32] !== 32'h1234) begin n_fail++; $display("FAIL raw_bypass got=%h exp=1234", rd_data[63:32]); end
    tick();
    idle();
    #1;
    n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL raw_busy_cnt_clear got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_waw_same_cycle();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall got=%b exp=1", stall); end
    tick();
    n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL waw_not_accepted got=%0d exp=1", busy_cnt); end
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0909;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL waw_wb_release got=%b exp=0", stall); end
    tick();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    #1;
    n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL waw_cnt_net_zero got=%0d exp=1", busy_cnt); end
    n_checks++; if (rd_busy !== 2'b01 || stall !== 1'b1) begin n_fail++; $display("FAIL waw_issue_wins got=%b/%b exp=01/1", rd_busy, stall); end
    n_checks++; if (rd_data[31:0] !== 32'h0000_0909) begin n_fail++; $display("FAIL waw_write_kept got=%h exp=00000909", rd_data[31:0]); end
    // Drain r9 so later tests start from an empty scoreboard.
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h0;
    tick();
    idle();
    #1;
    n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL waw_drain got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_reg0();
    idle();
    tick();
    issue_valid = 1'b1; issue_rd = 5'd0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    rd_addr = {5'd0, 5'd0}; rd_en = 2'b11;
    #1;
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL r0_bypass got=%h exp=0", rd_data); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall got=%b exp=0", stall); end
    tick();
    idle();
    rd_en = 2'b11;
    #1;
    n_checks++; if (busy_cnt !== 6'd0 || rd_busy !== 2'b00) begin n_fail++; $display("FAIL r0_busy got=%0d/%b exp=0/00", busy_cnt, rd_busy); end
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL r0_trace got=%b exp=0", trace_valid); end
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL r0_stored got=%h exp=0", rd_data); end
  endtask

  task automatic test_back_to_back();
    idle();
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'hAAAA5555;
    tick();
    wb_rd = 5'd5; wb_data = 32'h5555AAAA;
    rd_addr = {5'd5, 5'd4};
    #1;
    n_checks++; if (rd_data !== {32'h5555AAAA, 32'hAAAA5555}) begin n_fail++; $display("FAIL b2b_read got=%h exp=5555aaaaaaaa5555", rd_data); end
    tick();
    n_checks++; if (trace_valid !== 1'b1 || trace_rd !== 5'd5 || trace_data !== 32'h5555AAAA) begin
      n_fail++; $display("FAIL b2b_trace got=%b/%0d/%h exp=1/5/5555aaaa", trace_valid, trace_rd, trace_data); end
  endtask

  task automatic test_reset_mid();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    issue_rd = 5'd5;
    tick();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd4};
    #1;
    n_checks++; if (busy_cnt !== 6'd2 || stall !== 1'b1) begin n_fail++; $display("FAIL mid_pre got=%0d/%b exp=2/1", busy_cnt, stall); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy_cnt !== 6'd0 || stall !== 1'b0) begin n_fail++; $display("FAIL mid_reset got=%0d/%b exp=0/0", busy_cnt, stall); end
    n_checks++; if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL mid_reset_r4 got=%h exp=0", rd_data[31:0]); end
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
    tick();
    idle();
    rst_n = 1'b1;
    rd_addr = {5'd6, 5'd5};
    #1;
    n_checks++; if (rd_data !== 64'h0 || trace_valid !== 1'b0) begin n_fail++; $display("FAIL mid_wb_lost got=%h/%b exp=0/0", rd_data, trace_valid); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_load_use_raw();
    test_waw_same_cycle();
    test_reg0();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
